lsu: RTL and testbench

- Load/store unit sitting directly downstream of the ALU in the execute stage.
- Takes the ALU result as the effective address, together with store data and access attributes from decode.
- Performs one data-memory transaction at a time over a req/gnt/rvalid bus.
- Returns aligned, sign- or zero-extended load data to writeback, or an error pulse for misaligned accesses.

---
 rtl/lsu.sv | 181 ++++++++++++++++++
 tb/tb_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction at a time, with
// misalignment detection, lane steering and load extension. Define LSU_TIMEOUT_EN for a bus watchdog.
module lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t     state;
  logic       we_q;
  logic       sign_ext_q;
  logic [1:0] size_q;
  logic [1:0] off_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             cnt_expired;
  assign cnt_expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog limit is only meaningful with the timeout build.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_enables = 4'b0001 << off;
      2'b01:   byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] replicate(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] wd);
    case (size)
      2'b00:   replicate = {4{wd[7:0]}};
      2'b01:   replicate = {2{wd[15:0]}};
      default: replicate = wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [1:0] size,
                                                        input logic sx,
                                                        input logic [1:0] off,
                                                        input logic [DATA_WIDTH-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   extend_load = {{(DATA_WIDTH-8){sx & b[7]}}, b};
      2'b01:   extend_load = {{(DATA_WIDTH-16){sx & h[15]}}, h};
      default: extend_load = rd;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ready_o      <= 1'b1;
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_wdata_o <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rdata_o      <= '0;
      we_q         <= 1'b0;
      sign_ext_q   <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            we_q       <= we_i;
            sign_ext_q <= sign_ext_i;
            size_q     <= size_i;
            off_q      <= addr_i[1:0];
            if (misaligned(size_i, addr_i[1:0])) begin
              // Rejected without touching the bus; LSU stays ready.
              err_o <= 1'b1;
            end else begin
              state        <= REQ;
              ready_o      <= 1'b0;
              data_req_o   <= 1'b1;
              data_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
              data_we_o    <= we_i;
              data_be_o    <= byte_enables(size_i, addr_i[1:0]);
              data_wdata_o <= replicate(size_i, wdata_i);
`ifdef LSU_TIMEOUT_EN
              cnt          <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            state      <= WAIT;
            data_req_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt        <= '0;
          end else if (cnt_expired) begin
            state      <= IDLE;
            data_req_o <= 1'b0;
            ready_o    <= 1'b1;
            err_o      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
`endif
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
            if (!we_q) rdata_o <= extend_load(size_q, sign_ext_q, off_q, data_rdata_i);
`ifdef LSU_TIMEOUT_EN
          end else if (cnt_expired) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            err_o   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
`endif
          end
        end
        default: begin
          state      <= IDLE;
          ready_o    <= 1'b1;
          data_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, reset-while-waiting and
// timeout sequences, then randomized operations against a byte-level reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;

  lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .we_i(we_i), .size_i(size_i), .sign_ext_i(sign_ext_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t tbl[$];

  // Reference model: byte-level view of an access.
  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || ((a % nbytes(sz)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be = '0;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nbytes(sz)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    logic [31:0] v = rd >> (8 * (a % 4));
    logic [31:0] mask;
    if (n >= 4) return rd;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    if (sx && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int gd, input int rvd, input logic x_err, input logic [31:0] x_addr,
                       input logic [3:0] x_be, input logic [31:0] x_wdata,
                       input logic [31:0] x_rdata);
    valid_i = 1'b1; we_i = we; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    valid_i = 1'b0; addr_i = $urandom(); wdata_i = $urandom();
    if (x_err) begin
      chk({tag, " err pulse"}, 32'(err_o), 32'd1);
      chk({tag, " no req"}, 32'(data_req_o), 32'd0);
      chk({tag, " ready"}, 32'(ready_o), 32'd1);
      chk({tag, " no done"}, 32'(done_o), 32'd0);
      @(posedge clk); #1;
      chk({tag, " err one cycle"}, 32'(err_o), 32'd0);
      chk({tag, " still no req"}, 32'(data_req_o), 32'd0);
    end else begin
      chk({tag, " req"}, 32'(data_req_o), 32'd1);
      chk({tag, " not ready"}, 32'(ready_o), 32'd0);
      chk({tag, " no err"}, 32'(err_o), 32'd0);
      chk({tag, " addr"}, data_addr_o, x_addr);
      chk({tag, " be"}, 32'(data_be_o), 32'(x_be));
      chk({tag, " we"}, 32'(data_we_o), 32'(we));
      if (we) chk({tag, " wdata"}, data_wdata_o, x_wdata);
      repeat (gd) begin
        @(posedge clk); #1;
        chk({tag, " req held"}, 32'(data_req_o), 32'd1);
        chk({tag, " addr held"}, data_addr_o, x_addr);
        chk({tag, " be held"}, 32'(data_be_o), 32'(x_be));
      end
      data_gnt_i = 1'b1;
      @(posedge clk); #1;
      data_gnt_i = 1'b0;
      chk({tag, " req dropped"}, 32'(data_req_o), 32'd0);
      repeat (rvd) begin
        @(posedge clk); #1;
        chk({tag, " early done"}, 32'(done_o), 32'd0);
      end
      data_rvalid_i = 1'b1; data_rdata_i = rd;
      @(posedge clk); #1;
      data_rvalid_i = 1'b0; data_rdata_i = $urandom();
      chk({tag, " done"}, 32'(done_o), 32'd1);
      chk({tag, " err with done"}, 32'(err_o), 32'd0);
      chk({tag, " ready again"}, 32'(ready_o), 32'd1);
      chk({tag, " rdata_o"}, rdata_o, x_rdata);
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, 32'(done_o), 32'd0);
    end
  endtask

  logic [31:0] mdl_rdata;

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; we_i = 1'b0; size_i = 2'd0; sign_ext_i = 1'b0;
    addr_i = '0; wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;

    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 1'b0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1'b0, 32'h100, 4'b1000, 32'h0, 32'h00000080});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h00000080});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80017FFF, 1'b0, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5, 32'h0, 1'b0, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'hFFFF8001});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h203, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h80017FFF, 1'b0, 32'h100, 4'b0011, 32'h0, 32'h00007FFF});

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready_o), 32'd1);
    chk("reset req", 32'(data_req_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset err", 32'(err_o), 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    chk("reset be", 32'(data_be_o), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr,
            tbl[i].wdata, tbl[i].rdata, 0, 0, tbl[i].err, tbl[i].x_addr, tbl[i].x_be,
            tbl[i].x_wdata, tbl[i].x_rdata);

    // Reset arrives while the grant is being withheld.
    valid_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sign_ext_i = 1'b0; addr_i = 32'h500;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("rstwait req c1", 32'(data_req_o), 32'd1);
    chk("rstwait addr c1", data_addr_o, 32'h500);
    @(posedge clk); #1;
    chk("rstwait req c2", 32'(data_req_o), 32'd1);
    chk("rstwait addr c2", data_addr_o, 32'h500);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstwait req dropped", 32'(data_req_o), 32'd0);
    chk("rstwait ready", 32'(ready_o), 32'd1);
    chk("rstwait rdata cleared", rdata_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rstwait no done", 32'(done_o), 32'd0);
      chk("rstwait no err", 32'(err_o), 32'd0);
      chk("rstwait idle req", 32'(data_req_o), 32'd0);
      @(posedge clk); #1;
    end
    mdl_rdata = 32'h0;

`ifdef LSU_TIMEOUT_EN
    begin
      int hi;
      valid_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h600;
      @(posedge clk); #1;
      valid_i = 1'b0;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
        if (!data_req_o) break;
        hi++;
        @(posedge clk); #1;
      end
      chk("timeout req cycles", 32'(hi), 32'd4);
      chk("timeout err", 32'(err_o), 32'd1);
      chk("timeout ready", 32'(ready_o), 32'd1);
      chk("timeout no done", 32'(done_o), 32'd0);
      data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
      @(posedge clk); #1;
      data_rvalid_i = 1'b0;
      chk("late rvalid no done", 32'(done_o), 32'd0);
      chk("late rvalid rdata", rdata_o, 32'd0);
    end
`endif

    for (int n = 0; n < 60; n++) begin
      logic        we, sx, e;
      logic [1:0]  sz;
      logic [31:0] a, wd, rd;
      we = 1'(($urandom() & 1));
      sx = 1'(($urandom() & 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom();
      wd = $urandom();
      rd = $urandom();
      e  = m_err(sz, a);
      if (!e && !we) mdl_rdata = m_load(sz, sx, a, rd);
      do_op($sformatf("rnd%0d", n), we, sz, sx, a, wd, rd, $urandom_range(0, 3),
            $urandom_range(0, 3), e, {a[31:2], 2'b00}, m_be(sz, a), m_wdata(sz, wd), mdl_rdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
